uart_rx_cfg: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_cfg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and frame helper for the UART blocks
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Total bits on the wire for one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator shared by RX and TX
module uart_baud_tick #(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUD_RATE  = 1000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIVIDER = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    generate
        if (DIVIDER < 1) begin : g_bad_divider
            $error("uart_baud_tick: clock too slow for BAUD_RATE*OVERSAMPLE");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Count 0..DIVIDER-1 and wrap; never stops so TX and RX share one phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority sampling and valid/ready output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUD_RATE  = 1000000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_P1   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DB_CNT    = 4'(DATA_BITS);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_SENSE = (PARITY == PARITY_ODD);

    generate
        if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx_cfg: OVERSAMPLE must be even in 8..16");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_rx_cfg: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    logic tick;

    uart_baud_tick #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic rx_s1, rx_s2, rx_prev;
    logic [SW-1:0] samp_cnt;
    logic samp_a, samp_b;
    logic [3:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic par_err_acc, ferr_acc;

    rx_state_t state, next_state;

    logic clr_samp, shift_en, par_chk, stop_chk, frame_done;
    logic clear_acc, bit_inc, bit_clr;

    // Edge detect and majority use only the synchronized line.
    wire fall      = rx_prev & ~rx_s2;
    wire maj       = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    wire at_decide = tick && (samp_cnt == S_P1);
    wire at_end    = tick && (samp_cnt == S_LAST);
    wire last_stop = (bit_cnt == LAST_STOP);

    // Two-flop synchronizer plus one history flop for start-edge detection; idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the last stop bit returns to IDLE at its decision point so a
    // start edge in the second half of that bit is not missed.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (fall) next_state = ST_START;
            end
            ST_START: begin
                if (at_decide && maj)  next_state = ST_IDLE;
                else if (at_end)       next_state = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && bit_cnt == DB_CNT)
                    next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (at_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (at_decide && last_stop) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        clr_samp   = (state == ST_IDLE) && fall;
        shift_en   = (state == ST_DATA) && at_decide;
        par_chk    = (state == ST_PARITY) && at_decide;
        stop_chk   = (state == ST_STOP) && at_decide;
        frame_done = stop_chk && last_stop;
        clear_acc  = (state == ST_START);
        bit_inc    = shift_en || stop_chk;
        bit_clr    = ((state != ST_DATA) && (state != ST_STOP)) ||
                     ((state == ST_DATA) && at_end && (bit_cnt == DB_CNT));
    end

    // Sample counter realigns to the start edge, then runs with the oversample tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
        end else if (clr_samp) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;
        end
    end

    // Capture the two samples before the decision point; the third is the live line.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick) begin
            if (samp_cnt == S_M1)  samp_a <= rx_s2;
            if (samp_cnt == S_MID) samp_b <= rx_s2;
        end
    end

    // Counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // LSB-first shift: after DATA_BITS shifts the first bit sits in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
        end
    end

    // Per-frame error accumulators, cleared while the start bit is being qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_acc <= 1'b0;
            ferr_acc    <= 1'b0;
        end else if (clear_acc) begin
            par_err_acc <= 1'b0;
            ferr_acc    <= 1'b0;
        end else begin
            if (par_chk)         par_err_acc <= (^shreg) ^ maj ^ ODD_SENSE;
            if (stop_chk && !maj) ferr_acc   <= 1'b1;
        end
    end

    // Output holding register with valid/ready handshake and overrun tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done && (!valid || ready)) begin
            data_out   <= shreg;
            parity_err <= par_err_acc;
            frame_err  <= ferr_acc | ~maj;
            valid      <= 1'b1;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            overrun    <= 1'b1;
        end else if (valid && ready) begin
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
